// File: rtl/pixel_readout_pkg.sv
// Shared defaults and sample/frame types for the pixel readout capture path.
package pixel_readout_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_NUM_PIX    = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef logic [DEF_DATA_W-1:0] pix_t;
  typedef pix_t [DEF_NUM_PIX-1:0] frame_t;

endpackage

// File: rtl/pixel_frame_fifo.sv
// Synchronous FIFO of whole frames. Pointers carry a wrap bit so that
// full and empty are distinguishable and count reaches DEPTH when full.
module pixel_frame_fifo
  import pixel_readout_pkg::*;
#(
  parameter type T     = frame_t,
  parameter int  DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  T                       wr_data,
  input  logic                   pop,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  T             mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Advance write/read pointers on accepted writes and pops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Frame storage.
  // NOTE: the array is deliberately not reset; the pointers alone define which
  // entries are live, and leaving memories out of reset lets them map to RAM.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pixel_readout.sv
// Pixel readout capture stage: samples the shared pixel bus under the read
// strobes, commits complete frames into a frame FIFO, and serialises queued
// frames one pixel per beat on a valid/ready stream.
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_PIX    = DEF_NUM_PIX,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PIX-1:0]            read,
  input  logic [DATA_W-1:0]             pixData,
  output logic [DATA_W-1:0]             out_data,
  output logic [$clog2(NUM_PIX)-1:0]    out_idx,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   frames_pending,
  output logic [7:0]                    drop_count,
  output logic                          proto_err,
  input  logic                          err_clr
);

  localparam int IDX_W = $clog2(NUM_PIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIX - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef logic [DATA_W-1:0] cap_pix_t;
  typedef cap_pix_t [NUM_PIX-1:0] cap_frame_t;

  cap_frame_t          stage;
  cap_frame_t          head;
  logic [NUM_PIX-1:0]  read_d;
  logic [NUM_PIX-1:0]  got;
  logic [NUM_PIX-1:0]  fell;
  logic                multi;
  logic                commit;
  logic                frame_ok;
  logic                wr;
  logic                drop;
  logic                beat;
  logic                pop;
  logic                full;
  logic                empty;
  logic [IDX_W-1:0]    b;

  // Strobe decode. A frame is complete only if every pixel's strobe has fallen
  // since the last commit, including the last pixel falling on this very edge.
  assign multi    = $countones(read) > 1;
  assign fell     = read_d & ~read;
  assign commit   = fell[NUM_PIX-1];
  assign frame_ok = (&(got | fell)) && !multi;

  // A full FIFO still accepts the commit when the head frame leaves on the same edge.
  assign beat = out_valid && out_ready;
  assign pop  = beat && (b == LAST_IDX);
  assign wr   = commit && frame_ok && (!full || pop);
  assign drop = commit && !wr;

  // Stream view of the head frame; data is forced to zero while nothing is queued.
  assign out_valid = !empty;
  assign out_idx   = b;
  assign out_last  = out_valid && (b == LAST_IDX);
  assign out_data  = out_valid ? head[b] : '0;

  // Capture: a lone strobe loads its pixel's slot every cycle, so the last sample wins.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= '0;
    end else if (!multi) begin
      for (int k = 0; k < NUM_PIX; k++) begin
        if (read[k]) stage[k] <= pixData;
      end
    end
  end

  // Edge history and per-pixel completion flags; a bus conflict poisons the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_d <= '0;
      got    <= '0;
    end else begin
      read_d <= read;
      if (commit || multi) got <= '0;
      else                 got <= got | fell;
    end
  end

  // Error reporting; a clear wins over a same-cycle set or increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err  <= 1'b0;
      drop_count <= '0;
    end else if (err_clr) begin
      proto_err  <= 1'b0;
      drop_count <= '0;
    end else begin
      if (multi) proto_err <= 1'b1;
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

  // Beat counter walks the head frame and wraps only when the frame is popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b <= '0;
    end else if (beat) begin
      b <= (b == LAST_IDX) ? '0 : b + IDX_ONE;
    end
  end

  pixel_frame_fifo #(
    .T     (cap_frame_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .wr_data (stage),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (frames_pending)
  );

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: a table of single frames streamed with the
// consumer ready, then hand-built backpressure, full-FIFO, and reset sequences.
module tb_pixel_readout;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] read;
  logic [DW-1:0] pixData;
  logic [DW-1:0] out_data;
  logic [1:0]    out_idx;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    frames_pending;
  logic [7:0]    drop_count;
  logic          proto_err;
  logic          err_clr;

  int errors = 0;
  int checks = 0;

  typedef logic [NP-1:0][DW-1:0] frm_t;

  typedef struct {
    frm_t          px;
    logic [NP-1:0] skip;
    bit            multi;
    bit            streams;
    logic [7:0]    exp_drop;
    bit            exp_perr;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  pixel_readout #(
    .DATA_W     (DW),
    .NUM_PIX    (NP),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .read           (read),
    .pixData        (pixData),
    .out_data       (out_data),
    .out_idx        (out_idx),
    .out_last       (out_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .frames_pending (frames_pending),
    .drop_count     (drop_count),
    .proto_err      (proto_err),
    .err_clr        (err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame f, pixel k carries ((f+1) << 4) + k.
  function automatic frm_t mk(input int f);
    for (int k = 0; k < NP; k++) mk[k] = 8'((f + 1) * 16 + k);
  endfunction

  task automatic drive(input logic [NP-1:0] r, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    read    = r;
    pixData = d;
  endtask

  // Strobes each non-skipped pixel for 3 cycles with the real sample on the
  // last one, then drops all strobes. The commit edge is the next posedge.
  // ready_cyc > 0 raises out_ready together with that numbered drive cycle.
  task automatic send_frame(input frm_t px, input logic [NP-1:0] skip,
                            input bit multi, input int ready_cyc);
    int n = 0;
    for (int k = 0; k < NP; k++) begin
      if (skip[k]) continue;
      if (multi && k == 2) continue;
      if (multi && k == 1) begin
        n++;
        drive(4'b0110, px[1]);
        if (n == ready_cyc) out_ready = 1'b1;
        continue;
      end
      for (int c = 0; c < 3; c++) begin
        n++;
        drive(NP'(1) << k, (c == 2) ? px[k] : 8'hE0 + 8'(c));
        if (n == ready_cyc) out_ready = 1'b1;
      end
    end
    drive('0, 8'h00);
  endtask

  // Checks the beat presented at the current negedge, then moves to the next one.
  task automatic expect_beat(input string tag, input logic [DW-1:0] d, input int i);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".idx"},   32'(out_idx),   32'(i));
    check({tag, ".last"},  32'(out_last),  32'(i == NP - 1));
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int first_f, input int nframes);
    frm_t f;
    for (int j = 0; j < nframes; j++) begin
      f = mk(first_f + j);
      for (int k = 0; k < NP; k++)
        expect_beat($sformatf("%s.f%0d.b%0d", tag, j, k), f[k], k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{px: {8'h44, 8'h33, 8'h22, 8'h11}, skip: 4'b0000, multi: 1'b0,
                streams: 1'b1, exp_drop: 8'd0, exp_perr: 1'b0};
    vecs[1] = '{px: {8'hA4, 8'hA3, 8'hA2, 8'hA1}, skip: 4'b0100, multi: 1'b0,
                streams: 1'b0, exp_drop: 8'd1, exp_perr: 1'b0};
    vecs[2] = '{px: {8'h88, 8'h77, 8'h66, 8'h55}, skip: 4'b0000, multi: 1'b0,
                streams: 1'b1, exp_drop: 8'd1, exp_perr: 1'b0};
    vecs[3] = '{px: {8'hD4, 8'hD3, 8'hD2, 8'hD1}, skip: 4'b0000, multi: 1'b1,
                streams: 1'b0, exp_drop: 8'd2, exp_perr: 1'b1};

    reset = 1'b1; read = '0; pixData = '0; out_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.valid",   32'(out_valid),      32'd0);
    check("rst.data",    32'(out_data),       32'd0);
    check("rst.idx",     32'(out_idx),        32'd0);
    check("rst.last",    32'(out_last),       32'd0);
    check("rst.pending", 32'(frames_pending), 32'd0);
    check("rst.drop",    32'(drop_count),     32'd0);
    check("rst.perr",    32'(proto_err),      32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single frames with the consumer always ready.
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].px, vecs[v].skip, vecs[v].multi, 0);
      @(negedge clk);
      check($sformatf("v%0d.pre_valid", v), 32'(out_valid), 32'd0);
      @(negedge clk);
      if (vecs[v].streams) begin
        for (int k = 0; k < NP; k++)
          expect_beat($sformatf("v%0d.b%0d", v, k), vecs[v].px[k], k);
      end
      check($sformatf("v%0d.post_valid", v), 32'(out_valid),  32'd0);
      check($sformatf("v%0d.drop", v),       32'(drop_count), 32'(vecs[v].exp_drop));
      check($sformatf("v%0d.perr", v),       32'(proto_err),  32'(vecs[v].exp_perr));
    end

    // Error clear.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr.perr", 32'(proto_err),  32'd0);
    check("clr.drop", 32'(drop_count), 32'd0);

    // Backpressure: five frames into a four-deep FIFO.
    out_ready = 1'b0;
    for (int f = 0; f < 5; f++) send_frame(mk(f), 4'b0000, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("bp.pending", 32'(frames_pending), 32'd4);
    check("bp.drop",    32'(drop_count),     32'd1);
    @(negedge clk);
    check("bp.hold_valid", 32'(out_valid), 32'd1);
    check("bp.hold_data",  32'(out_data),  32'h10);
    check("bp.hold_idx",   32'(out_idx),   32'd0);
    out_ready = 1'b1;
    drain("bp", 0, 4);
    check("bp.empty_valid",   32'(out_valid),      32'd0);
    check("bp.empty_pending", 32'(frames_pending), 32'd0);

    // Commit lands on the same edge as the final-beat pop of a full FIFO.
    out_ready = 1'b0;
    for (int f = 5; f < 9; f++) send_frame(mk(f), 4'b0000, 1'b0, 0);
    send_frame(mk(9), 4'b0000, 1'b0, 10);
    @(negedge clk);
    check("sim.pre_idx",     32'(out_idx),        32'd3);
    check("sim.pre_pending", 32'(frames_pending), 32'd4);
    @(negedge clk);
    check("sim.pending", 32'(frames_pending), 32'd4);
    check("sim.drop",    32'(drop_count),     32'd1);
    drain("sim", 6, 4);
    check("sim.empty_valid", 32'(out_valid), 32'd0);

    // Reset while beat 2 of a queued frame is on the bus.
    out_ready = 1'b0;
    send_frame(mk(10), 4'b0000, 1'b0, 0);
    send_frame(mk(11), 4'b0000, 1'b0, 0);
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("mid.idx",  32'(out_idx),  32'd2);
    check("mid.data", 32'(out_data), 32'hB2);
    reset = 1'b1;
    #1;
    check("mrst.valid",   32'(out_valid),      32'd0);
    check("mrst.pending", 32'(frames_pending), 32'd0);
    check("mrst.idx",     32'(out_idx),        32'd0);
    check("mrst.data",    32'(out_data),       32'd0);
    check("mrst.drop",    32'(drop_count),     32'd0);
    @(negedge clk);
    reset = 1'b0;
    send_frame(mk(12), 4'b0000, 1'b0, 0);
    repeat (2) @(negedge clk);
    drain("post", 12, 1);
    check("post.valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
